posit_decode: RTL and testbench
===============================

# posit_decode

Streaming decoder that converts POSIT_WIDTH-bit encoded posits into the denormalized field set (sign, scale, fraction without hidden bit, NaR, zero) consumed by the posit arithmetic units such as the multiplier. It sits between the operand source (memory/stream reader) and the arithmetic pipelines. It uses the same rts/rtr/sow/eow handshake, skid latch and stage_en/stage_clr pipeline discipline as the arithmetic blocks.

## Interface
- POSIT_WIDTH, 16, encoded posit width N (N >= 5)
- POSIT_ES, 1, exponent field width ES
- Derived FW = `GET_FRACTION_WIDTH(POSIT_WIDTH, POSIT_ES, 0)` = N-ES-3; SW = `GET_SCALE_WIDTH(POSIT_WIDTH, POSIT_ES, 0)` = clog2(N)+ES+1
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- rts_i  in  1  upstream ready to send
- rtr_o  out  1  ready to receive (registered)
- sow_i / eow_i  in  1  start/end of window, travel with data
- posit_i  in  N  encoded posit
- rtr_i  in  1  downstream ready to receive
- rts_o  out  1  output valid
- sow_o / eow_o  out  1  delayed sow_i/eow_i
- fraction_o  out  FW  fraction, MSB-aligned, hidden bit removed
- scale_o  out  SW signed  k*2^ES + e
- sign_o  out  1  posit sign bit
- NaR_o  out  1  input was 1000...0
- zero_o  out  1  input was 0

## Operation
- process_en = rtr_i | ~rts_o; receive_en = rts_i & rtr_o.
- rtr_o <= process_en each cycle.
- Skid latch: on receive_en & ~process_en, capture posit_i/sow_i/eow_i and set latched; clear latched on process_en. Stage-1 input mux selects latched copy when latched=1.
- Stage 1 (stage_en[0] = process_en & (receive_en | latched); stage_clr[0] = process_en & ~receive_en & ~latched): register sign = p[N-1], zero = (p==0), NaR = (p==1<<(N-1)), body = two's complement of p if sign else p (low N-1 bits), regime bit r0 = body[N-2], run length m = count of leading bits equal to r0 (1..N-1).
- Stage 2 (same enable/clear rule, driven by staged[0]): k = r0 ? m-1 : -m; shift body left by m+1 (drop regime and terminator); e = next ES bits, zero-filled if truncated; fraction_o = following FW bits, zero-filled; scale_o = k*2^ES + e.
- Zero or NaR: fraction_o = 0, scale_o = 0; sign_o still raw p[N-1].
- Maxpos (no terminator, m = N-1): shift saturates, e = 0, fraction = 0.
- Width rule: scale computed in SW bits signed; no overflow possible for legal N/ES.

## Timing
- Reset: rtr_o=0, rts_o=0, sow_o=0, eow_o=0, fraction_o=0, scale_o=0, sign_o=0, NaR_o=0, zero_o=0, latched=0, staged=0. rtr_o rises 1 cycle after reset release.
- Latency: 2 cycles from accepted beat to rts_o (1 cycle with macro, see Configuration).
- Throughput 1 beat/cycle while rtr_i=1.
- Outputs hold stable while rts_o=1 & rtr_i=0.
- rtr_o lags process_en by 1 cycle; exactly one in-flight beat on rtr_i drop is absorbed by the skid latch; no loss, no duplication.
- Simultaneous latch capture and release impossible (mutually exclusive conditions); latched beat drains before new input.
- Reset mid-stream discards all in-flight beats; no partial output after release.

## Configuration
- POSIT_DECODE_SINGLE_STAGE_EN: defined -> stages 1 and 2 merged into one registered stage, latency 1, PIPELEN=1. Undefined -> two-stage pipeline, latency 2. Field results identical in both.

## Test plan
- N=16, ES=1: 0x4000 -> sign 0, scale 0, frac 0x000; 0x5000 -> scale 1, frac 0; 0x6000 -> scale 2; 0x4800 -> scale 0, frac 0x800.
- 0xC000 -> sign 1, scale 0, frac 0; 0xB800 (-1.5) -> sign 1, scale 0, frac 0x800.
- 0x0000 -> zero_o=1, NaR_o=0; 0x8000 -> NaR_o=1, zero_o=0; 0x0001 -> scale -28, frac 0; 0x7FFF -> scale 28, frac 0.
- Stream 10 beats with sow on beat 0, eow on beat 9, rtr_i held 1 -> 10 outputs in order, 2-cycle latency, sow_o/eow_o aligned to beats 0/9.
- Same stream, rtr_i low for 3 random cycles -> output sequence identical, no drop/duplicate, outputs stable while stalled.
- Assert rst_n low with 2 beats in flight -> all outputs 0 immediately; after release, rts_o=0 until new beat accepted.

Source files
------------

// File: rtl/posit_decode_if.sv
// Stream handshake plus decoded posit field bundle used by posit_decode.
interface posit_decode_if #(
  parameter int unsigned POSIT_WIDTH = 16,
  parameter int unsigned POSIT_ES    = 1
);
  localparam int unsigned FW = POSIT_WIDTH - POSIT_ES - 3;
  localparam int unsigned SW = $clog2(POSIT_WIDTH) + POSIT_ES + 1;

  logic                   rts_i;
  logic                   rtr_o;
  logic                   sow_i;
  logic                   eow_i;
  logic [POSIT_WIDTH-1:0] posit_i;
  logic                   rtr_i;
  logic                   rts_o;
  logic                   sow_o;
  logic                   eow_o;
  logic [FW-1:0]          fraction_o;
  logic signed [SW-1:0]   scale_o;
  logic                   sign_o;
  logic                   NaR_o;
  logic                   zero_o;

  modport slave (
    input  rts_i, sow_i, eow_i, posit_i, rtr_i,
    output rtr_o, rts_o, sow_o, eow_o, fraction_o, scale_o, sign_o, NaR_o, zero_o
  );

  modport master (
    output rts_i, sow_i, eow_i, posit_i, rtr_i,
    input  rtr_o, rts_o, sow_o, eow_o, fraction_o, scale_o, sign_o, NaR_o, zero_o
  );
endinterface

// File: rtl/posit_decode.sv
// Streaming posit decoder: encoded posit -> sign/scale/fraction/NaR/zero fields.
// Define POSIT_DECODE_SINGLE_STAGE_EN to merge both stages into one (latency 1).
module posit_decode #(
  parameter int unsigned POSIT_WIDTH = 16,
  parameter int unsigned POSIT_ES    = 1
) (
  input logic           clk,
  input logic           rst_n,
  posit_decode_if.slave bus
);
  localparam int unsigned N  = POSIT_WIDTH;
  localparam int unsigned BW = N - 1;
  localparam int unsigned MW = $clog2(N);
  localparam int unsigned FW = N - POSIT_ES - 3;
  localparam int unsigned SW = $clog2(N) + POSIT_ES + 1;

  logic w_process_en, w_receive_en, w_in_valid;
  logic r_rtr, r_rts;
  logic r_latched, r_skid_sow, r_skid_eow;
  logic [N-1:0] r_skid_posit;
  logic [N-1:0] w_p;
  logic w_sow, w_eow;

  assign w_process_en = bus.rtr_i | ~r_rts;
  assign w_receive_en = bus.rts_i & r_rtr;
  assign w_in_valid   = w_receive_en | r_latched;
  assign w_p          = r_latched ? r_skid_posit : bus.posit_i;
  assign w_sow        = r_latched ? r_skid_sow : bus.sow_i;
  assign w_eow        = r_latched ? r_skid_eow : bus.eow_i;

  // rtr_o lags process_en, so one beat can land while stalled; the skid holds it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rtr        <= 1'b0;
      r_latched    <= 1'b0;
      r_skid_posit <= '0;
      r_skid_sow   <= 1'b0;
      r_skid_eow   <= 1'b0;
    end else begin
      r_rtr <= w_process_en;
      if (w_receive_en && !w_process_en) begin
        r_latched    <= 1'b1;
        r_skid_posit <= bus.posit_i;
        r_skid_sow   <= bus.sow_i;
        r_skid_eow   <= bus.eow_i;
      end else if (w_process_en) begin
        r_latched <= 1'b0;
      end
    end
  end

  logic w_d_sign, w_d_zero, w_d_nar, w_d_r0, w_stop;
  logic [N-1:0]  w_neg;
  logic [BW-1:0] w_d_body;
  logic [MW-1:0] w_d_run;

  always_comb begin
    w_neg    = -w_p;
    w_d_sign = w_p[N-1];
    w_d_zero = (w_p == '0);
    w_d_nar  = (w_p == {1'b1, {(N-1){1'b0}}});
    w_d_body = w_d_sign ? w_neg[BW-1:0] : w_p[BW-1:0];
    w_d_r0   = w_d_body[BW-1];
    w_d_run  = '0;
    w_stop   = 1'b0;
    for (int i = BW - 1; i >= 0; i--) begin
      if (!w_stop && (w_d_body[i] == w_d_r0)) w_d_run = w_d_run + MW'(1);
      else w_stop = 1'b1;
    end
  end

  logic w_s2_valid, w_s2_sow, w_s2_eow, w_s2_sign, w_s2_zero, w_s2_nar, w_s2_r0;
  logic [BW-1:0] w_s2_body;
  logic [MW-1:0] w_s2_run;

`ifdef POSIT_DECODE_SINGLE_STAGE_EN
  assign w_s2_valid = w_in_valid;
  assign w_s2_sow   = w_sow;
  assign w_s2_eow   = w_eow;
  assign w_s2_sign  = w_d_sign;
  assign w_s2_zero  = w_d_zero;
  assign w_s2_nar   = w_d_nar;
  assign w_s2_r0    = w_d_r0;
  assign w_s2_body  = w_d_body;
  assign w_s2_run   = w_d_run;
`else
  logic r_s1_valid, r_s1_sow, r_s1_eow, r_s1_sign, r_s1_zero, r_s1_nar, r_s1_r0;
  logic [BW-1:0] r_s1_body;
  logic [MW-1:0] r_s1_run;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_valid <= 1'b0;
      r_s1_sow   <= 1'b0;
      r_s1_eow   <= 1'b0;
      r_s1_sign  <= 1'b0;
      r_s1_zero  <= 1'b0;
      r_s1_nar   <= 1'b0;
      r_s1_r0    <= 1'b0;
      r_s1_body  <= '0;
      r_s1_run   <= '0;
    end else if (w_process_en && w_in_valid) begin
      r_s1_valid <= 1'b1;
      r_s1_sow   <= w_sow;
      r_s1_eow   <= w_eow;
      r_s1_sign  <= w_d_sign;
      r_s1_zero  <= w_d_zero;
      r_s1_nar   <= w_d_nar;
      r_s1_r0    <= w_d_r0;
      r_s1_body  <= w_d_body;
      r_s1_run   <= w_d_run;
    end else if (w_process_en) begin
      r_s1_valid <= 1'b0;
      r_s1_sow   <= 1'b0;
      r_s1_eow   <= 1'b0;
    end
  end

  assign w_s2_valid = r_s1_valid;
  assign w_s2_sow   = r_s1_sow;
  assign w_s2_eow   = r_s1_eow;
  assign w_s2_sign  = r_s1_sign;
  assign w_s2_zero  = r_s1_zero;
  assign w_s2_nar   = r_s1_nar;
  assign w_s2_r0    = r_s1_r0;
  assign w_s2_body  = r_s1_body;
  assign w_s2_run   = r_s1_run;
`endif

  logic [BW-1:0]        w_shifted;
  logic [FW-1:0]        w_frac;
  logic signed [SW-1:0] w_scale;
  int                   w_k, w_e;

  // Shifting out regime + terminator; a shift >= BW (maxpos/minpos) yields all zeros.
  always_comb begin
    w_shifted = w_s2_body << (int'(w_s2_run) + 1);
    w_e       = int'(w_shifted >> (BW - POSIT_ES));
    w_k       = w_s2_r0 ? int'(w_s2_run) - 1 : -int'(w_s2_run);
    w_scale   = SW'(w_k * (2 ** POSIT_ES) + w_e);
    w_frac    = w_shifted[BW-1-POSIT_ES -: FW];
    if (w_s2_zero || w_s2_nar) begin
      w_scale = '0;
      w_frac  = '0;
    end
  end

  logic r_sow, r_eow, r_sign, r_zero, r_nar;
  logic [FW-1:0]        r_frac;
  logic signed [SW-1:0] r_scale;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rts   <= 1'b0;
      r_sow   <= 1'b0;
      r_eow   <= 1'b0;
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
      r_nar   <= 1'b0;
      r_frac  <= '0;
      r_scale <= '0;
    end else if (w_process_en && w_s2_valid) begin
      r_rts   <= 1'b1;
      r_sow   <= w_s2_sow;
      r_eow   <= w_s2_eow;
      r_sign  <= w_s2_sign;
      r_zero  <= w_s2_zero;
      r_nar   <= w_s2_nar;
      r_frac  <= w_frac;
      r_scale <= w_scale;
    end else if (w_process_en) begin
      r_rts <= 1'b0;
      r_sow <= 1'b0;
      r_eow <= 1'b0;
    end
  end

  assign bus.rtr_o      = r_rtr;
  assign bus.rts_o      = r_rts;
  assign bus.sow_o      = r_sow;
  assign bus.eow_o      = r_eow;
  assign bus.sign_o     = r_sign;
  assign bus.zero_o     = r_zero;
  assign bus.NaR_o      = r_nar;
  assign bus.fraction_o = r_frac;
  assign bus.scale_o    = r_scale;
endmodule

// File: tb/tb_posit_decode.sv
// Bench for posit_decode: bit-queue reference decoder, scoreboard and directed streams.
module tb_posit_decode;
  localparam int unsigned N  = 16;
  localparam int unsigned ES = 1;
  localparam int unsigned FW = N - ES - 3;
`ifdef POSIT_DECODE_SINGLE_STAGE_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int sign; int zero; int nar; int scale; int frac; int sow; int eow; int acc;
  } exp_t;

  typedef struct {
    logic [15:0] p; int sign; int zero; int nar; int scale; int frac;
  } vec_t;

  vec_t vecs[14] = '{
    '{16'h4000, 0, 0, 0,   0, 0},     '{16'h5000, 0, 0, 0,   1, 0},
    '{16'h6000, 0, 0, 0,   2, 0},     '{16'h4800, 0, 0, 0,   0, 'h800},
    '{16'hC000, 1, 0, 0,   0, 0},     '{16'hB800, 1, 0, 0,   0, 'h800},
    '{16'h0000, 0, 1, 0,   0, 0},     '{16'h8000, 1, 0, 1,   0, 0},
    '{16'h0001, 0, 0, 0, -28, 0},     '{16'h7FFF, 0, 0, 0,  28, 0},
    '{16'h7FFE, 0, 0, 0,  26, 0},     '{16'h0003, 0, 0, 0, -25, 0},
    '{16'h3FFF, 0, 0, 0,  -1, 'hFFF}, '{16'hFFFF, 1, 0, 0, -28, 0}
  };

  logic clk = 1'b0;
  logic rst_n;

  posit_decode_if #(.POSIT_WIDTH(N), .POSIT_ES(ES)) bus ();

  posit_decode #(.POSIT_WIDTH(N), .POSIT_ES(ES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_out   = 0;
  bit chk_lat = 1'b0;
  bit front_seen = 1'b0;
  exp_t sb[$];
  logic [N-1:0] stim[$];

  task automatic chk(input string name, input logic signed [31:0] act,
                     input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: walk the magnitude bits as a queue: regime run, terminator, ES, fraction.
  function automatic exp_t ref_decode(input logic [N-1:0] p);
    exp_t r;
    bit   q[$];
    bit   r0;
    int   a, run, k, ex, fr;
    r = '{default: 0};
    r.sign = int'(p[N-1]);
    r.zero = (p == 0) ? 1 : 0;
    r.nar  = (p == (1 << (N - 1))) ? 1 : 0;
    if (r.zero == 1 || r.nar == 1) return r;
    a = (r.sign == 1) ? (1 << N) - int'(p) : int'(p);
    for (int i = N - 2; i >= 0; i--) q.push_back(a[i]);
    r0  = q[0];
    run = 0;
    while (q.size() > 0 && q[0] == r0) begin
      run++;
      void'(q.pop_front());
    end
    if (q.size() > 0) void'(q.pop_front());
    k  = (r0 == 1'b1) ? run - 1 : -run;
    ex = 0;
    for (int i = 0; i < int'(ES); i++) ex = ex * 2 + ((q.size() > 0) ? int'(q.pop_front()) : 0);
    fr = 0;
    for (int i = 0; i < int'(FW); i++) fr = fr * 2 + ((q.size() > 0) ? int'(q.pop_front()) : 0);
    r.scale = k * (1 << ES) + ex;
    r.frac  = fr;
    return r;
  endfunction

  task automatic compare_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sb.delete();
        front_seen = 1'b0;
        continue;
      end
      if (bus.rts_o) begin
        if (sb.size() == 0) begin
          chk("spurious_rts_o", bus.rts_o, 0);
        end else begin
          e = sb[0];
          chk("sign_o", bus.sign_o, e.sign);
          chk("zero_o", bus.zero_o, e.zero);
          chk("NaR_o", bus.NaR_o, e.nar);
          chk("scale_o", bus.scale_o, e.scale);
          chk("fraction_o", bus.fraction_o, e.frac);
          chk("sow_o", bus.sow_o, e.sow);
          chk("eow_o", bus.eow_o, e.eow);
          if (!front_seen && chk_lat) chk("latency", cyc - e.acc, LAT);
          front_seen = 1'b1;
          if (bus.rtr_i) begin
            void'(sb.pop_front());
            front_seen = 1'b0;
            n_out++;
          end
        end
      end
      if (bus.rts_i && bus.rtr_o) begin
        e     = ref_decode(bus.posit_i);
        e.sow = int'(bus.sow_i);
        e.eow = int'(bus.eow_i);
        e.acc = cyc;
        sb.push_back(e);
      end
    end
  endtask

  task automatic send_stream(input bit stall, input bit lat);
    int idx, guard, g, s0, s1, s2;
    idx     = 0;
    guard   = 0;
    n_out   = 0;
    chk_lat = lat;
    s0 = int'($urandom_range(3, 5));
    s1 = s0 + int'($urandom_range(1, 3));
    s2 = s1 + int'($urandom_range(1, 3));
    while (idx < stim.size() && guard < 200) begin
      @(posedge clk);
      #1;
      bus.rts_i   = 1'b1;
      bus.posit_i = stim[idx];
      bus.sow_i   = (idx == 0);
      bus.eow_i   = (idx == stim.size() - 1);
      bus.rtr_i   = !(stall && (guard == s0 || guard == s1 || guard == s2));
      @(negedge clk);
      if (bus.rtr_o) idx++;
      guard++;
    end
    chk("beats_accepted", idx, stim.size());
    @(posedge clk);
    #1;
    bus.rts_i = 1'b0;
    bus.sow_i = 1'b0;
    bus.eow_i = 1'b0;
    bus.rtr_i = 1'b1;
    g = 0;
    while (sb.size() > 0 && g < 50) begin
      @(negedge clk);
      g++;
    end
    repeat (4) @(negedge clk);
    chk("drain_empty", sb.size(), 0);
    chk("out_count", n_out, stim.size());
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_rtr_o"}, bus.rtr_o, 0);
    chk({tag, "_rts_o"}, bus.rts_o, 0);
    chk({tag, "_sow_o"}, bus.sow_o, 0);
    chk({tag, "_eow_o"}, bus.eow_o, 0);
    chk({tag, "_fraction_o"}, bus.fraction_o, 0);
    chk({tag, "_scale_o"}, bus.scale_o, 0);
    chk({tag, "_sign_o"}, bus.sign_o, 0);
    chk({tag, "_NaR_o"}, bus.NaR_o, 0);
    chk({tag, "_zero_o"}, bus.zero_o, 0);
  endtask

  initial begin
    exp_t m;
    bus.rts_i   = 1'b0;
    bus.sow_i   = 1'b0;
    bus.eow_i   = 1'b0;
    bus.posit_i = '0;
    bus.rtr_i   = 1'b1;
    rst_n       = 1'b0;
    fork
      compare_loop();
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("reset");

    // Pin the reference model to hand-computed values.
    foreach (vecs[i]) begin
      m = ref_decode(vecs[i].p);
      chk($sformatf("model_sign_%h", vecs[i].p), m.sign, vecs[i].sign);
      chk($sformatf("model_zero_%h", vecs[i].p), m.zero, vecs[i].zero);
      chk($sformatf("model_nar_%h", vecs[i].p), m.nar, vecs[i].nar);
      chk($sformatf("model_scale_%h", vecs[i].p), m.scale, vecs[i].scale);
      chk($sformatf("model_frac_%h", vecs[i].p), m.frac, vecs[i].frac);
    end

    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rtr_o_at_release", bus.rtr_o, 0);
    @(posedge clk);
    #1;
    chk("rtr_o_one_cycle_after", bus.rtr_o, 1);

    stim.delete();
    foreach (vecs[i]) stim.push_back(vecs[i].p);
    send_stream(1'b0, 1'b1);

    stim.delete();
    for (int i = 0; i < 10; i++) stim.push_back(N'($urandom));
    send_stream(1'b0, 1'b1);
    send_stream(1'b1, 1'b0);

    // Reset with beats in flight.
    chk_lat = 1'b0;
    @(posedge clk);
    #1;
    bus.rts_i   = 1'b1;
    bus.sow_i   = 1'b1;
    bus.posit_i = 16'hB800;
    @(posedge clk);
    #1;
    bus.sow_i   = 1'b0;
    bus.posit_i = 16'h7FFF;
    @(posedge clk);
    #1;
    bus.posit_i = 16'h3FFF;
    @(posedge clk);
    #1;
    bus.rts_i = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk_all_zero("midreset");
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rts_o_after_midreset", bus.rts_o, 0);
    end

    stim.delete();
    stim.push_back(16'h4800);
    stim.push_back(16'hC000);
    send_stream(1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish before time limit");
    $fatal(1, "watchdog expired");
  end
endmodule
